// File: rtl/fwd_hazard_scoreboard.sv
// Operand-forwarding selector with load-use / multicycle stall generation for the ID/EX boundary.
// Define FWD_HAZARD_PERF_EN to add saturating stall and forward performance counters.
module fwd_hazard_scoreboard #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned NSTAGE   = 3,
   parameter int unsigned LD_READY = 2,
   parameter int unsigned MC_LAT   = 4,
   parameter int unsigned SEL_W    = $clog2(NSTAGE + 1)
) (
   input  logic              CLK,
   input  logic              Reset_L,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_rw,
   input  logic              id_regwrite,
   input  logic              id_ld,
   input  logic              id_mc,
   output logic [SEL_W-1:0]  fwd_sel_a,
   output logic [SEL_W-1:0]  fwd_sel_b,
   output logic              stall,
   output logic              mc_busy,
   output logic              mc_done,
`ifdef FWD_HAZARD_PERF_EN
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_fwd_cnt,
`endif
   output logic [REG_AW-1:0] mc_rw
);

   localparam int unsigned CNT_W = $clog2(MC_LAT);

   logic [NSTAGE-1:0]             stValidQ, stValidD, stWrQ, stWrD, stLdQ, stLdD;
   logic [NSTAGE-1:0][REG_AW-1:0] stRwQ, stRwD;

   logic              mcBusyQ, mcBusyD, mcDoneQ, mcDoneD;
   logic [CNT_W-1:0]  mcCntQ, mcCntD;
   logic [REG_AW-1:0] mcRwQ, mcRwD;

   logic [SEL_W:0] lookA, lookB;
   logic           pendA, pendB, mcPend, mcDepA, mcDepB, enter, issue;

   // Returns {notReady, sel}; the youngest (lowest stage) producer wins.
   function automatic logic [SEL_W:0] lookup(
      input logic [REG_AW-1:0]             src,
      input logic                          srcUsed,
      input logic [NSTAGE-1:0]             vld,
      input logic [NSTAGE-1:0]             wr,
      input logic [NSTAGE-1:0]             ld,
      input logic [NSTAGE-1:0][REG_AW-1:0] rw
   );
      logic           found;
      logic [SEL_W:0] res;
      found = 1'b0;
      res   = '0;
      for (int unsigned k = 0; k < NSTAGE; k++) begin
         if (!found && vld[k] && wr[k] && rw[k] == src) begin
            found = 1'b1;
            if (!ld[k] || k + 1 >= LD_READY) res = {1'b0, SEL_W'(k + 1)};
            else                             res = {1'b1, {SEL_W{1'b0}}};
         end
      end
      if (!srcUsed || src == '0) res = '0;
      return res;
   endfunction

   assign lookA     = lookup(id_rs, id_use_rs, stValidQ, stWrQ, stLdQ, stRwQ);
   assign lookB     = lookup(id_rt, id_use_rt, stValidQ, stWrQ, stLdQ, stRwQ);
   assign fwd_sel_a = lookA[SEL_W-1:0];
   assign fwd_sel_b = lookB[SEL_W-1:0];
   assign pendA     = lookA[SEL_W];
   assign pendB     = lookB[SEL_W];

   // The mc result is never forwarded, so its readers wait until the done cycle.
   assign mcPend = mcBusyQ && !mcDoneQ;
   assign mcDepA = id_use_rs && id_rs != '0 && id_rs == mcRwQ;
   assign mcDepB = id_use_rt && id_rt != '0 && id_rt == mcRwQ;
   assign stall  = id_valid && !flush &&
                   (pendA || pendB || (mcPend && (mcDepA || mcDepB || id_mc)));
   assign enter  = id_valid && !flush && !stall;
   assign issue  = enter && id_mc;

   always_comb begin
      stValidD    = stValidQ;
      stWrD       = stWrQ;
      stLdD       = stLdQ;
      stRwD       = stRwQ;
      stValidD[0] = enter;
      stRwD[0]    = id_rw;
      stWrD[0]    = id_regwrite && !id_mc;
      stLdD[0]    = id_ld;
      for (int unsigned k = 1; k < NSTAGE; k++) begin
         stValidD[k] = stValidQ[k-1];
         stWrD[k]    = stWrQ[k-1];
         stLdD[k]    = stLdQ[k-1];
         stRwD[k]    = stRwQ[k-1];
      end
   end

   always_comb begin
      mcBusyD = mcBusyQ;
      mcCntD  = mcCntQ;
      mcRwD   = mcRwQ;
      mcDoneD = mcBusyQ && mcCntQ == CNT_W'(1);
      if (mcCntQ != '0) mcCntD = mcCntQ - CNT_W'(1);
      if (mcDoneQ)      mcBusyD = 1'b0;
      // A back-to-back issue in the done cycle reloads instead of releasing the unit.
      if (issue) begin
         mcBusyD = 1'b1;
         mcCntD  = CNT_W'(MC_LAT - 1);
         mcRwD   = id_rw;
      end
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         stValidQ <= '0;
         stWrQ    <= '0;
         stLdQ    <= '0;
         stRwQ    <= '0;
         mcBusyQ  <= 1'b0;
         mcDoneQ  <= 1'b0;
         mcCntQ   <= '0;
         mcRwQ    <= '0;
      end else begin
         stValidQ <= stValidD;
         stWrQ    <= stWrD;
         stLdQ    <= stLdD;
         stRwQ    <= stRwD;
         mcBusyQ  <= mcBusyD;
         mcDoneQ  <= mcDoneD;
         mcCntQ   <= mcCntD;
         mcRwQ    <= mcRwD;
      end
   end

   assign mc_busy = mcBusyQ;
   assign mc_done = mcDoneQ;
   assign mc_rw   = mcRwQ;

`ifdef FWD_HAZARD_PERF_EN
   logic [31:0] perfStallQ, perfFwdQ;
   logic        fwdHit;

   assign fwdHit = id_valid && !stall && (fwd_sel_a != '0 || fwd_sel_b != '0);

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         perfStallQ <= '0;
         perfFwdQ   <= '0;
      end else begin
         if (stall && perfStallQ != '1) perfStallQ <= perfStallQ + 32'd1;
         if (fwdHit && perfFwdQ != '1)  perfFwdQ   <= perfFwdQ + 32'd1;
      end
   end

   assign perf_stall_cnt = perfStallQ;
   assign perf_fwd_cnt   = perfFwdQ;
`endif

endmodule
